// File: rtl/strobe_launcher_if.sv
// Word-source handshake between a bench sequencer and strobe_launcher:
// one data/enable word plus the setup/hold margins it is to be launched with.
interface strobe_launcher_if #(
   parameter int CNT_W  = 8,
   parameter int DATA_W = 1
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_en;
   logic [CNT_W-1:0]  cfg_setup;
   logic [CNT_W-1:0]  cfg_hold;

   modport master (
      output in_valid, in_data, in_en, cfg_setup, cfg_hold,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, in_en, cfg_setup, cfg_hold,
      output in_ready
   );
endinterface

// File: rtl/strobe_launcher.sv
// Strobe launcher: divides ck into sck and launches each buffered word cfg_setup ticks
// before the next sck posedge. Optional macro STROBE_LAUNCHER_IDLE_X_EN drives sdata to x outside the window.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_EMPTY  | no word buffered; reaching the launch phase counts an underrun
// S_LOADED | one word buffered, waiting for the launch phase
module strobe_launcher #(
   parameter int PERIOD = 100,
   parameter int CNT_W  = 8,
   parameter int DATA_W = 1
) (
   input  logic              ck,
   input  logic              rst_n,
   strobe_launcher_if.slave  src,
   output logic              sck,
   output logic [DATA_W-1:0] sdata,
   output logic              sen,
   output logic              cfg_err,
   output logic [7:0]        underrun_cnt
);

   localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] PH_HALF  = CNT_W'(PERIOD / 2);
   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
   localparam logic [CNT_W:0]   PERIOD_W = (CNT_W + 1)'(PERIOD);

   typedef enum logic {S_EMPTY, S_LOADED} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  phase_q, phase_d;
   logic [CNT_W-1:0]  launch_ph_q, launch_ph_d;
   logic [CNT_W-1:0]  hold_q, hold_d;
   logic [DATA_W-1:0] word_data_q, word_data_d;
   logic              word_en_q, word_en_d;
   logic              sck_q, sck_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic              sen_q, sen_d;
   logic              err_q, err_d;
   logic [7:0]        ucnt_q, ucnt_d;

   logic              accept;
   logic              cfg_bad;
   logic              at_launch;
   logic [CNT_W:0]    cfg_sum;

   assign src.in_ready = (state_q == S_EMPTY);

   always_comb begin
      phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      sck_d       = (phase_d < PH_HALF);
      state_d     = state_q;
      launch_ph_d = launch_ph_q;
      hold_d      = hold_q;
      word_data_d = word_data_q;
      word_en_d   = word_en_q;
      sdata_d     = sdata_q;
      sen_d       = sen_q;
      err_d       = 1'b0;
      ucnt_d      = ucnt_q;

      accept    = src.in_valid && (state_q == S_EMPTY);
      cfg_sum   = {1'b0, src.cfg_setup} + {1'b0, src.cfg_hold};
      cfg_bad   = (src.cfg_setup == '0) ||
                  ({1'b0, src.cfg_setup} >= PERIOD_W) ||
                  (cfg_sum > PERIOD_W);
      at_launch = (phase_d == launch_ph_q);

`ifdef STROBE_LAUNCHER_IDLE_X_EN
      // Poison the data once the hold window after the posedge has closed.
      if ((hold_q != '0) && (phase_d == hold_q) && !(state_q == S_LOADED && at_launch))
         sdata_d = 'x;
`endif

      case (state_q)
         S_EMPTY: begin
            if (at_launch) begin
               sen_d = 1'b0;
               if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
            end
            // Acceptance uses the old launch phase above, so a word landing on
            // its own launch edge waits a full period.
            if (accept) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  word_data_d = src.in_data;
                  word_en_d   = src.in_en;
                  launch_ph_d = PERIOD_C - src.cfg_setup;
                  hold_d      = src.cfg_hold;
                  state_d     = S_LOADED;
               end
            end
         end
         S_LOADED: begin
            if (at_launch) begin
               sdata_d = word_data_q;
               sen_d   = word_en_q;
               state_d = S_EMPTY;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         phase_q     <= '0;
         launch_ph_q <= PH_HALF;
         hold_q      <= '0;
         word_data_q <= '0;
         word_en_q   <= 1'b0;
         sck_q       <= 1'b1;
         sdata_q     <= '0;
         sen_q       <= 1'b0;
         err_q       <= 1'b0;
         ucnt_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         launch_ph_q <= launch_ph_d;
         hold_q      <= hold_d;
         word_data_q <= word_data_d;
         word_en_q   <= word_en_d;
         sck_q       <= sck_d;
         sdata_q     <= sdata_d;
         sen_q       <= sen_d;
         err_q       <= err_d;
         ucnt_q      <= ucnt_d;
      end
   end

   assign sck          = sck_q;
   assign sdata        = sdata_q;
   assign sen          = sen_q;
   assign cfg_err      = err_q;
   assign underrun_cnt = ucnt_q;

endmodule
